fetch_unit: RTL

- Instruction-fetch stage of the RISC CPU.
- Owns the program counter and drives the word address into the instruction memory, which is combinational and word-aligned.
- Captures the returned instruction word into the IF/ID pipeline register for the decoder.
- Handles hazard-unit stalls, branch redirects and pipeline flushes, and keeps a retired-fetch counter for performance debug.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives imem_addr, and captures the fetched word into IF/ID.
// Latency: the word at imem_addr is in IF/ID one edge later. Throughput is 1 instruction per cycle.
// Backpressure: stall holds the PC, IF/ID and the counter. A branch overrides a stall. Flush squashes IF/ID.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   stall, flush               hazard-unit controls
//   branch_taken/target        redirect from execute; the target is word-aligned internally
//   imem_addr / imem_instr     combinational instruction-memory interface (addr = PC)
//   if_id_instr/pc/pc_plus4    registered IF/ID payload
//   if_id_valid                the IF/ID payload is a real instruction
//   fetch_count                number of valid words written into IF/ID (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_id_pc;
  logic [31:0]      r_id_pc_plus4;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_pc;

  // The 32-bit add wraps naturally: 0xFFFF_FFFC + 4 gives 0.
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_branch_pc = {branch_target[31:2], 2'b00};

  // The address depends only on the PC register. Control inputs act on the next edge.
  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_id_pc;
  assign if_id_pc_plus4 = r_id_pc_plus4;
  assign if_id_valid    = r_valid;
  assign fetch_count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_valid       <= 1'b0;
      r_count       <= '0;
    end else begin
      case (r_state)
        // One bubble edge after reset release lets imem_instr settle before the first capture.
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (branch_taken) begin
            // A redirect beats stall and flush. The word fetched this cycle is discarded.
            r_pc    <= w_branch_pc;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else if (stall) begin
            // Hold everything.
          end else if (flush) begin
            r_pc    <= w_pc_plus4;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else begin
            r_instr       <= imem_instr;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
            r_valid       <= 1'b1;
            r_pc          <= w_pc_plus4;
            r_count       <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule
